// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, controller states and operation-class helper.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two's-complement conditional negate: magnitude on entry (neg = sign bit),
// sign restoration on exit (neg = result must be negative).
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per CALC
// cycle on operand magnitudes, with sign fix applied when the result is registered.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int TAGW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [TAGW-1:0]   rd_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [TAGW-1:0]   rd_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DWIDTH + 1);

  state_t              state, state_next;
  logic [2*DWIDTH-1:0] acc, acc_next, res_src, res_fix;
  logic [DWIDTH-1:0]   b_mag, a_mag_in, b_mag_in, special_res, calc_res;
  logic [DWIDTH:0]     add_sum, rem_sh, rem_diff;
  logic [CW-1:0]       cnt;
  logic [2:0]          f3;
  logic [DWIDTH-1:0]   res_q;
  logic [TAGW-1:0]     rd_q;
  logic                res_neg, accept, a_signed, b_signed, a_neg, b_neg;
  logic                div_zero, div_ovf, special;

  // Handshakes: a request transfers on a clock edge where valid_i && ready_o
  // (and no flush); a result transfers on an edge where valid_o && ready_i.
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);
  assign res_o   = res_q;
  assign rd_o    = rd_q;
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    a_signed = (funct3_i != F3_MULHU) && (funct3_i != F3_DIVU) && (funct3_i != F3_REMU);
    b_signed = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
               (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  end

  assign a_neg = a_signed && rs1_i[DWIDTH-1];
  assign b_neg = b_signed && rs2_i[DWIDTH-1];

  muldiv_signfix #(.W(DWIDTH)) u_abs_a (.a(rs1_i), .neg(a_neg), .y(a_mag_in));
  muldiv_signfix #(.W(DWIDTH)) u_abs_b (.a(rs2_i), .neg(b_neg), .y(b_mag_in));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero = is_div(funct3_i) && (rs2_i == '0);
  assign div_ovf  = is_div(funct3_i) && !funct3_i[0] &&
                    (rs1_i == {1'b1, {(DWIDTH-1){1'b0}}}) && (rs2_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3_i[1] ? rs1_i : '1;
    else          special_res = funct3_i[1] ? '0 : rs1_i;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh   = {acc[2*DWIDTH-1:DWIDTH], acc[DWIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_mag};
    acc_next = {add_sum, acc[DWIDTH-1:1]};
    if (is_div(f3)) begin
      if (!rem_diff[DWIDTH]) acc_next = {rem_diff[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b1};
      else                   acc_next = {rem_sh[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_src = acc_next;
    if (is_div(f3))
      res_src = f3[1] ? {{DWIDTH{1'b0}}, acc_next[2*DWIDTH-1:DWIDTH]}
                      : {{DWIDTH{1'b0}}, acc_next[DWIDTH-1:0]};
  end

  muldiv_signfix #(.W(2*DWIDTH)) u_fix_res (.a(res_src), .neg(res_neg), .y(res_fix));

  assign calc_res = (!is_div(f3) && (f3 != F3_MUL)) ? res_fix[2*DWIDTH-1:DWIDTH]
                                                   : res_fix[DWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      b_mag   <= '0;
      res_neg <= 1'b0;
      f3      <= '0;
      cnt     <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      acc     <= {{DWIDTH{1'b0}}, a_mag_in};
      b_mag   <= b_mag_in;
      f3      <= funct3_i;
      rd_q    <= rd_i;
      cnt     <= special ? '0 : CW'(DWIDTH);
      res_neg <= (is_div(funct3_i) && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      if (special) res_q <= special_res;
    end else if (state == CALC && !flush_i) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) res_q <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit: expected {rd, result} pairs are
// queued at issue time and popped by an independent result monitor.
module tb_muldiv_unit;

  localparam int DWIDTH = 32;
  localparam int TAGW   = 5;
  localparam int EW     = TAGW + DWIDTH;

  logic              clk, reset, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
  logic [DWIDTH-1:0] rs1_i, rs2_i, res_o;
  logic [2:0]        funct3_i;
  logic [TAGW-1:0]   rd_i, rd_o;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v, held_v;
  bit            holding = 0;

  muldiv_unit #(.DWIDTH(DWIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .res_o(res_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // reference model: RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // driver: waits for ready, presents one request for the accept edge
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    int n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) note_fail("ready_timeout");
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0;
    rs1_i = $urandom; rs2_i = $urandom;
    funct3_i = 3'($urandom); rd_i = 5'($urandom);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int stall);
    int lat;
    int exp_lat;
    exp_q.push_back({rd, ref_model(f3, a, b)});
    exp_lat = is_special(f3, a, b) ? 1 : DWIDTH + 1;
    start_op(f3, a, b, rd);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (stall > 0) begin
      ready_i = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        check("stall_ready_o", ready_o, 1'b0);
      end
      ready_i = 1'b1;
    end
    @(posedge clk); #1;
    check("ready_after_handshake", ready_o, 1'b1);
    check("valid_after_handshake", valid_o, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && valid_o) begin
      if (!holding) begin
        if (exp_q.size() == 0) note_fail("unexpected_result");
        else begin
          exp_v = exp_q.pop_front();
          check("result", {rd_o, res_o}, exp_v);
        end
        held_v  = {rd_o, res_o};
        holding = 1;
      end else begin
        check("stall_hold", {rd_o, res_o}, held_v);
      end
      if (ready_i) holding = 0;
    end else begin
      holding = 0;
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          mode;

    reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    rs1_i = '0; rs2_i = '0; funct3_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_o", ready_o, 1'b1);
    check("reset_valid_o", valid_o, 1'b0);
    check("reset_busy_o", busy_o, 1'b0);
    check("reset_res_o", res_o, 32'h0);
    check("reset_rd_o", rd_o, 5'h0);
    reset = 1'b0;

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd11, 0);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    issue(3'b101, 32'd100, 32'd7, 5'd6, 0);
    issue(3'b111, 32'd100, 32'd7, 5'd7, 0);
    issue(3'b101, 32'd5, 32'd0, 5'd8, 0);
    issue(3'b110, 32'd5, 32'd0, 5'd9, 0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // backpressure
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 10);

    // flush mid-calculation with a competing request in the same cycle
    start_op(3'b000, 32'd9, 32'd9, 5'd14);
    repeat (11) begin @(posedge clk); #1; end
    flush_i = 1'b1; valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd1; rs2_i = 32'd1;
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_busy_o", busy_o, 1'b0);
    check("flush_ready_o", ready_o, 1'b1);
    check("flush_valid_o", valid_o, 1'b0);
    repeat (40) begin @(posedge clk); #1; end
    check("flush_no_result", valid_o, 1'b0);

    // reset mid-calculation
    start_op(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd15);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_ready_o", ready_o, 1'b1);
    check("midreset_valid_o", valid_o, 1'b0);
    check("midreset_busy_o", busy_o, 1'b0);
    check("midreset_res_o", res_o, 32'h0);
    check("midreset_rd_o", rd_o, 5'h0);
    issue(3'b000, 32'd3, 32'd4, 5'd16, 0);

    // randomised operations
    for (int i = 0; i < 40; i++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      else if (mode == 3) b = $urandom_range(1, 3);
      issue(f3, a, b, 5'($urandom), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
